mux_sel_arbiter: RTL and testbench

MUX_SEL_ARBITER -- requirements
Module: mux_sel_arbiter

---
 rtl/mux_sel_arbiter_if.sv | 38 +++
 rtl/mux_sel_arbiter.sv | 127 ++++++++++++
 tb/tb_mux_sel_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_sel_arbiter_if.sv
// -----------------------------------------------------------------------------
// mux_sel_arbiter_if
// Groups the request/grant, mux feedback and output handshake signals of the
// mux select arbiter.
//   en, req       : arbitration enable and per-source requests
//   mux_y         : word returned by the external 8:1 mux
//   sel, gnt      : mux select and one-hot grant
//   dout,
//   dout_valid,
//   dout_ready    : captured word and its valid/ready handshake
//   busy          : arbiter is not idle
//   xfer_cnt      : completed transfer count (wraps)
// Modports: slave = arbiter side, master = requester/consumer side.
// -----------------------------------------------------------------------------
interface mux_sel_arbiter_if #(
    parameter int DW = 6
);
    logic          en;
    logic [7:0]    req;
    logic [DW-1:0] mux_y;
    logic          dout_ready;
    logic [2:0]    sel;
    logic [7:0]    gnt;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          busy;
    logic [7:0]    xfer_cnt;

    modport slave (
        input  en, req, mux_y, dout_ready,
        output sel, gnt, dout, dout_valid, busy, xfer_cnt
    );

    modport master (
        output en, req, mux_y, dout_ready,
        input  sel, gnt, dout, dout_valid, busy, xfer_cnt
    );
endinterface

// File: rtl/mux_sel_arbiter.sv
// -----------------------------------------------------------------------------
// mux_sel_arbiter
// Round-robin arbiter that steers an external 8:1 mux, waits one cycle for the
// mux to settle, captures the mux output and presents it on a valid/ready
// handshake.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mux_sel_arbiter_if.slave (en, req, mux_y, dout_ready in;
//           sel, gnt, dout, dout_valid, busy, xfer_cnt out)
// -----------------------------------------------------------------------------
module mux_sel_arbiter #(
    parameter int DW   = 6,
    parameter int NSRC = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    mux_sel_arbiter_if.slave bus
);
    localparam int SW = $clog2(NSRC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEL   = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [SW-1:0]   r_ptr;
    logic [SW-1:0]   r_sel;
    logic [NSRC-1:0] r_gnt;
    logic [DW-1:0]   r_dout;
    logic            r_dout_valid;
    logic [7:0]      r_xfer_cnt;

    logic [SW-1:0]   w_win;
    logic [SW-1:0]   w_idx;
    logic            w_any;
    logic            w_grant;
    logic            w_capture;
    logic            w_done;

    // Round-robin pick: scan from the highest offset down so the last hit,
    // i.e. the smallest offset from r_ptr, is the one that sticks.
    always_comb begin
        w_win = r_ptr;
        w_idx = r_ptr;
        w_any = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            w_idx = r_ptr + SW'(i);
            if (bus.req[w_idx]) begin
                w_win = w_idx;
                w_any = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_grant   = 1'b0;
        w_capture = 1'b0;
        w_done    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.en && w_any) begin
                    w_grant = 1'b1;
                    w_next  = SEL;
                end
            end
            SEL: begin
                w_capture = 1'b1;
                w_next    = VALID;
            end
            VALID: begin
                if (bus.dout_ready) begin
                    w_done = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // sel/gnt are latched once at grant time, so req changes during SEL/VALID
    // cannot disturb the mux path or the eventual pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr        <= '0;
            r_sel        <= '0;
            r_gnt        <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_xfer_cnt   <= '0;
        end else begin
            if (w_grant) begin
                r_sel <= w_win;
                r_gnt <= {{(NSRC-1){1'b0}}, 1'b1} << w_win;
            end
            if (w_capture) begin
                r_dout       <= bus.mux_y;
                r_dout_valid <= 1'b1;
            end
            if (w_done) begin
                r_dout_valid <= 1'b0;
                r_gnt        <= '0;
                r_ptr        <= r_sel + SW'(1);
                r_xfer_cnt   <= r_xfer_cnt + 8'd1;
            end
        end
    end

    assign bus.sel        = r_sel;
    assign bus.gnt        = r_gnt;
    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.busy       = (r_state != IDLE);
    assign bus.xfer_cnt   = r_xfer_cnt;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_sel_arbiter
// Self-checking bench for mux_sel_arbiter. The external 8:1 mux is modelled by
// indexing a source-data array with sel; expected grants come from a
// transaction-level round-robin model (pointer + transfer count).
// -----------------------------------------------------------------------------
module tb_mux_sel_arbiter;
    localparam int DW = 6;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] src_data [8];

    int total;
    int bad;
    int m_ptr;
    int m_cnt;

    mux_sel_arbiter_if #(.DW(DW)) bus ();

    assign bus.mux_y = src_data[bus.sel];

    mux_sel_arbiter #(.DW(DW), .NSRC(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int rr_pick(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        m_ptr = 0;
        m_cnt = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        bus.en = 1'b0;
        bus.req = 8'h00;
        bus.dout_ready = 1'b0;
        for (int k = 0; k < 8; k++) src_data[k] = 6'($urandom);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bus.sel !== 3'd0) begin bad++; $display("FAIL reset_sel: got %0d want 0", bus.sel); end
        total++; if (bus.gnt !== 8'h00) begin bad++; $display("FAIL reset_gnt: got %h want 00", bus.gnt); end
        total++; if (bus.dout !== 6'h00) begin bad++; $display("FAIL reset_dout: got %h want 00", bus.dout); end
        total++; if (bus.dout_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.dout_valid); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        total++; if (bus.xfer_cnt !== 8'h00) begin bad++; $display("FAIL reset_cnt: got %0d want 0", bus.xfer_cnt); end
        step();
        step();
        rst_n = 1'b1;
        m_ptr = 0;
        m_cnt = 0;
    endtask

    task automatic test_basic();
        src_data[0] = 6'h2A;
        bus.req = 8'h01;
        bus.en = 1'b1;
        bus.dout_ready = 1'b1;
        step();
        total++; if (bus.gnt !== 8'h01) begin bad++; $display("FAIL basic_gnt: got %h want 01", bus.gnt); end
        total++; if (bus.sel !== 3'd0) begin bad++; $display("FAIL basic_sel: got %0d want 0", bus.sel); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", bus.busy); end
        total++; if (bus.dout_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid: got %b want 0", bus.dout_valid); end
        step();
        total++; if (bus.dout !== 6'h2A) begin bad++; $display("FAIL basic_dout: got %h want 2a", bus.dout); end
        total++; if (bus.dout_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", bus.dout_valid); end
        step();
        total++; if (bus.xfer_cnt !== 8'd1) begin bad++; $display("FAIL basic_cnt: got %0d want 1", bus.xfer_cnt); end
        total++; if (bus.dout_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_one_cycle: got %b want 0", bus.dout_valid); end
        total++; if (bus.gnt !== 8'h00) begin bad++; $display("FAIL basic_gnt_clear: got %h want 00", bus.gnt); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL basic_idle: got %b want 0", bus.busy); end
        bus.req = 8'h00;
        m_ptr = 1;
        m_cnt = 1;
    endtask

    task automatic test_rotate();
        do_reset();
        bus.req = 8'hFF;
        bus.en = 1'b1;
        bus.dout_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            for (int k = 0; k < 8; k++) src_data[k] = 6'($urandom);
            step();
            total++; if (bus.sel !== 3'(i % 8)) begin bad++; $display("FAIL rotate_sel[%0d]: got %0d want %0d", i, bus.sel, i % 8); end
            total++; if (bus.gnt !== (8'h01 << (i % 8))) begin bad++; $display("FAIL rotate_gnt[%0d]: got %h want %h", i, bus.gnt, 8'h01 << (i % 8)); end
            step();
            total++; if (bus.dout !== src_data[i % 8]) begin bad++; $display("FAIL rotate_dout[%0d]: got %h want %h", i, bus.dout, src_data[i % 8]); end
            step();
            m_ptr = (i + 1) % 8;
            m_cnt = m_cnt + 1;
            if (i == 7) begin
                total++; if (bus.xfer_cnt !== 8'd8) begin bad++; $display("FAIL rotate_cnt8: got %0d want 8", bus.xfer_cnt); end
            end
        end
        bus.req = 8'h00;
    endtask

    task automatic test_ptr_priority();
        do_reset();
        bus.en = 1'b1;
        bus.dout_ready = 1'b1;
        bus.req = 8'h10;
        step();
        total++; if (bus.sel !== 3'd4) begin bad++; $display("FAIL prio_first_sel: got %0d want 4", bus.sel); end
        step();
        step();
        bus.req = 8'h21;
        step();
        total++; if (bus.sel !== 3'd5) begin bad++; $display("FAIL prio_ptr5_sel: got %0d want 5", bus.sel); end
        total++; if (bus.gnt !== 8'h20) begin bad++; $display("FAIL prio_ptr5_gnt: got %h want 20", bus.gnt); end
        step();
        step();
        step();
        total++; if (bus.sel !== 3'd0) begin bad++; $display("FAIL prio_wrap_sel: got %0d want 0", bus.sel); end
        step();
        step();
        total++; if (bus.xfer_cnt !== 8'd3) begin bad++; $display("FAIL prio_cnt: got %0d want 3", bus.xfer_cnt); end
        bus.req = 8'h00;
        m_ptr = 1;
        m_cnt = 3;
    endtask

    task automatic test_stall();
        logic [DW-1:0] d0;
        bus.en = 1'b1;
        bus.dout_ready = 1'b0;
        bus.req = 8'h04;
        step();
        total++; if (bus.sel !== 3'd2) begin bad++; $display("FAIL stall_sel: got %0d want 2", bus.sel); end
        step();
        total++; if (bus.dout !== src_data[2]) begin bad++; $display("FAIL stall_dout: got %h want %h", bus.dout, src_data[2]); end
        d0 = src_data[2];
        for (int c = 0; c < 10; c++) begin
            for (int k = 0; k < 8; k++) src_data[k] = 6'($urandom);
            src_data[2] = d0 ^ 6'($urandom_range(1, 63));
            bus.req = 8'($urandom);
            step();
            total++; if (bus.dout !== d0) begin bad++; $display("FAIL stall_hold_dout[%0d]: got %h want %h", c, bus.dout, d0); end
            total++; if (bus.sel !== 3'd2 || bus.gnt !== 8'h04) begin bad++; $display("FAIL stall_hold_sel[%0d]: got sel=%0d gnt=%h want sel=2 gnt=04", c, bus.sel, bus.gnt); end
            total++; if (bus.dout_valid !== 1'b1) begin bad++; $display("FAIL stall_hold_valid[%0d]: got %b want 1", c, bus.dout_valid); end
        end
        bus.req = 8'h00;
        bus.dout_ready = 1'b1;
        step();
        m_ptr = 3;
        m_cnt = m_cnt + 1;
        total++; if (bus.dout_valid !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL stall_done: got valid=%b busy=%b want 0 0", bus.dout_valid, bus.busy); end
        total++; if (bus.xfer_cnt !== 8'(m_cnt)) begin bad++; $display("FAIL stall_cnt: got %0d want %0d", bus.xfer_cnt, m_cnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.en = 1'b1;
        bus.dout_ready = 1'b0;
        bus.req = 8'h08;
        step();
        step();
        total++; if (bus.dout_valid !== 1'b1) begin bad++; $display("FAIL rstmid_pre_valid: got %b want 1", bus.dout_valid); end
        rst_n = 1'b0;
        #1;
        total++; if (bus.sel !== 3'd0 || bus.gnt !== 8'h00 || bus.dout !== 6'h00) begin bad++; $display("FAIL rstmid_outputs: got sel=%0d gnt=%h dout=%h want 0", bus.sel, bus.gnt, bus.dout); end
        total++; if (bus.dout_valid !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_flags: got valid=%b busy=%b want 0 0", bus.dout_valid, bus.busy); end
        total++; if (bus.xfer_cnt !== 8'd0) begin bad++; $display("FAIL rstmid_cnt: got %0d want 0", bus.xfer_cnt); end
        rst_n = 1'b1;
        step();
        total++; if (bus.gnt !== 8'h08 || bus.sel !== 3'd3) begin bad++; $display("FAIL rstmid_first_grant: got gnt=%h sel=%0d want 08 3", bus.gnt, bus.sel); end
        bus.dout_ready = 1'b1;
        step();
        step();
        total++; if (bus.xfer_cnt !== 8'd1) begin bad++; $display("FAIL rstmid_after_cnt: got %0d want 1", bus.xfer_cnt); end
        bus.req = 8'h00;
        m_ptr = 4;
        m_cnt = 1;
    endtask

    task automatic test_enable();
        bus.en = 1'b0;
        bus.req = 8'h10;
        bus.dout_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            total++; if (bus.busy !== 1'b0 || bus.gnt !== 8'h00) begin bad++; $display("FAIL en_low[%0d]: got busy=%b gnt=%h want 0 00", c, bus.busy, bus.gnt); end
        end
        bus.en = 1'b1;
        step();
        total++; if (bus.gnt !== 8'h10 || bus.sel !== 3'd4) begin bad++; $display("FAIL en_grant: got gnt=%h sel=%0d want 10 4", bus.gnt, bus.sel); end
        bus.en = 1'b0;
        bus.req = 8'h00;
        step();
        total++; if (bus.dout_valid !== 1'b1 || bus.dout !== src_data[4]) begin bad++; $display("FAIL en_noabort_dout: got valid=%b dout=%h want 1 %h", bus.dout_valid, bus.dout, src_data[4]); end
        step();
        m_ptr = 5;
        m_cnt = m_cnt + 1;
        total++; if (bus.xfer_cnt !== 8'(m_cnt) || bus.busy !== 1'b0) begin bad++; $display("FAIL en_noabort_done: got cnt=%0d busy=%b want %0d 0", bus.xfer_cnt, bus.busy, m_cnt); end
    endtask

    task automatic test_random();
        logic [7:0]    r;
        logic          e;
        int            dly;
        int            w;
        logic [DW-1:0] d;
        do_reset();
        for (int it = 0; it < 150; it++) begin
            for (int k = 0; k < 8; k++) src_data[k] = 6'($urandom);
            r = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            e = ($urandom_range(0, 3) != 0);
            dly = $urandom_range(0, 3);
            bus.req = r;
            bus.en = e;
            bus.dout_ready = (dly == 0);
            step();
            if (!(e && r != 8'h00)) begin
                total++; if (bus.busy !== 1'b0 || bus.gnt !== 8'h00) begin bad++; $display("FAIL rnd_nogrant[%0d]: got busy=%b gnt=%h want 0 00", it, bus.busy, bus.gnt); end
                continue;
            end
            w = rr_pick(r, m_ptr);
            total++; if (bus.sel !== 3'(w) || bus.gnt !== (8'h01 << w)) begin bad++; $display("FAIL rnd_grant[%0d]: got sel=%0d gnt=%h want sel=%0d req=%h ptr=%0d", it, bus.sel, bus.gnt, w, r, m_ptr); end
            bus.req = 8'($urandom);
            bus.en = 1'($urandom);
            step();
            total++; if (bus.dout !== src_data[w] || bus.dout_valid !== 1'b1) begin bad++; $display("FAIL rnd_capture[%0d]: got dout=%h valid=%b want %h 1", it, bus.dout, bus.dout_valid, src_data[w]); end
            d = src_data[w];
            for (int c = 0; c < dly; c++) begin
                for (int k = 0; k < 8; k++) src_data[k] = 6'($urandom);
                bus.req = 8'($urandom);
                bus.dout_ready = 1'b0;
                step();
                total++; if (bus.dout !== d || bus.dout_valid !== 1'b1 || bus.sel !== 3'(w)) begin bad++; $display("FAIL rnd_hold[%0d]: got dout=%h valid=%b sel=%0d want %h 1 %0d", it, bus.dout, bus.dout_valid, bus.sel, d, w); end
            end
            bus.dout_ready = 1'b1;
            step();
            m_ptr = (w + 1) % 8;
            m_cnt = (m_cnt + 1) % 256;
            total++; if (bus.dout_valid !== 1'b0 || bus.gnt !== 8'h00 || bus.busy !== 1'b0) begin bad++; $display("FAIL rnd_done[%0d]: got valid=%b gnt=%h busy=%b want 0 00 0", it, bus.dout_valid, bus.gnt, bus.busy); end
            total++; if (bus.sel !== 3'(w)) begin bad++; $display("FAIL rnd_sel_retain[%0d]: got %0d want %0d", it, bus.sel, w); end
            total++; if (bus.xfer_cnt !== 8'(m_cnt)) begin bad++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", it, bus.xfer_cnt, m_cnt); end
        end
        bus.req = 8'h00;
        bus.en = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        m_ptr = 0;
        m_cnt = 0;
        test_reset();
        test_basic();
        test_rotate();
        test_ptr_priority();
        test_stall();
        test_reset_mid();
        test_enable();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
